// File: rtl/instr_pkg.sv
// ---------------------------------------------------------------------------
// instr_pkg
// Shared constants for the MIPS subset encoder and the control decoder:
// request kind codes, opcode/funct values, the NOP word and the encoder FSM
// state type.
// Configuration macro: INSERT_DELAY_NOP_EN adds the NOP_PEND state.
// ---------------------------------------------------------------------------
package instr_pkg;

  // Request kind codes; 10..15 are illegal
  localparam logic [3:0] KIND_ADDU = 4'd0;
  localparam logic [3:0] KIND_SUBU = 4'd1;
  localparam logic [3:0] KIND_JR   = 4'd2;
  localparam logic [3:0] KIND_BEQ  = 4'd3;
  localparam logic [3:0] KIND_LUI  = 4'd4;
  localparam logic [3:0] KIND_LW   = 4'd5;
  localparam logic [3:0] KIND_ORI  = 4'd6;
  localparam logic [3:0] KIND_SW   = 4'd7;
  localparam logic [3:0] KIND_J    = 4'd8;
  localparam logic [3:0] KIND_JAL  = 4'd9;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // sll $0,$0,0 -- the canonical delay-slot filler
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FULL     = 2'd1
`ifdef INSERT_DELAY_NOP_EN
    ,
    ST_NOP_PEND = 2'd2
`endif
  } state_e;

  // Control-transfer kinds, which own a delay slot
  function automatic logic isDelayKind(input logic [3:0] kind);
    return (kind == KIND_JR) || (kind == KIND_BEQ) ||
           (kind == KIND_J)  || (kind == KIND_JAL);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// ---------------------------------------------------------------------------
// instr_pack
// Purely combinational packer: request kind plus register/immediate/target
// fields -> 32-bit MIPS word, with an illegal-kind flag.
// Ports:
//   i_kind    4   request kind code
//   i_rs/rt/rd 5  register fields
//   i_imm     16  immediate / branch offset
//   i_target  26  jump target field
//   o_word    32  encoded instruction (0 for illegal kinds)
//   o_illegal 1   kind code is outside the supported subset
// ---------------------------------------------------------------------------
module instr_pack
  import instr_pkg::*;
(
  input  logic [3:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  // Fields a kind does not use stay zero, and shamt is always zero
  always_comb begin
    o_word    = 32'h0000_0000;
    o_illegal = 1'b0;
    case (i_kind)
      KIND_ADDU: o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_ADDU};
      KIND_SUBU: o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_SUBU};
      KIND_JR:   o_word = {OP_RTYPE, i_rs, 5'd0, 5'd0, 5'd0, FN_JR};
      KIND_BEQ:  o_word = {OP_BEQ, i_rs, i_rt, i_imm};
      KIND_LUI:  o_word = {OP_LUI, 5'd0, i_rt, i_imm};
      KIND_LW:   o_word = {OP_LW, i_rs, i_rt, i_imm};
      KIND_ORI:  o_word = {OP_ORI, i_rs, i_rt, i_imm};
      KIND_SW:   o_word = {OP_SW, i_rs, i_rt, i_imm};
      KIND_J:    o_word = {OP_J, i_target};
      KIND_JAL:  o_word = {OP_JAL, i_target};
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Packs instruction requests into MIPS words and presents each one with its
// instruction-memory byte address on a one-deep registered valid/ready
// stream. Tracks a running address, a handshake count and flags illegal
// request kinds.
// Configuration macro: INSERT_DELAY_NOP_EN -- when defined, every handshaken
// jr/beq/j/jal word is followed by an automatic NOP word.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   restart      sync pulse, reload the address counter to BASE_ADDR
//   in_valid/in_ready   request handshake
//   in_kind, in_rs, in_rt, in_rd, in_imm, in_target   request fields
//   out_valid/out_ready output handshake
//   out_instr    encoded word, out_addr its byte address
//   err_illegal  one-cycle pulse after an illegal request is accepted
//   emit_cnt     words handshaken since reset (16-bit wrap)
// ---------------------------------------------------------------------------
module instr_encoder
  import instr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_illegal,
  output logic [15:0] emit_cnt
);

  logic [31:0] w_word;
  logic        w_illegal;
  logic        w_inReady;
  logic        w_inFire;
  logic        w_accept;
  logic        w_outFire;

  state_e      r_state;
  logic        r_outValid;
  logic [31:0] r_outInstr;
  logic [31:0] r_outAddr;
  logic        r_errIllegal;
  logic [15:0] r_emitCnt;
  logic        r_restartPend;
`ifdef INSERT_DELAY_NOP_EN
  logic        r_needNop;
`endif

  instr_pack u_pack (
    .i_kind    (in_kind),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_imm     (in_imm),
    .i_target  (in_target),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // In FULL the slot frees up in the same cycle the consumer takes the word,
  // so a new request can be accepted back-to-back. A word that still owes a
  // NOP cannot be replaced by a new request.
  always_comb begin
    w_inReady = 1'b0;
    case (r_state)
      ST_EMPTY: w_inReady = 1'b1;
`ifdef INSERT_DELAY_NOP_EN
      ST_FULL:  w_inReady = out_ready && !r_needNop;
`else
      ST_FULL:  w_inReady = out_ready;
`endif
      default:  w_inReady = 1'b0;
    endcase
  end

  assign w_inFire  = in_valid && w_inReady;
  assign w_accept  = w_inFire && !w_illegal;
  assign w_outFire = r_outValid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_EMPTY;
      r_outValid    <= 1'b0;
      r_outInstr    <= NOP_WORD;
      r_outAddr     <= BASE_ADDR;
      r_errIllegal  <= 1'b0;
      r_emitCnt     <= 16'd0;
      r_restartPend <= 1'b0;
`ifdef INSERT_DELAY_NOP_EN
      r_needNop     <= 1'b0;
`endif
    end else begin
      r_errIllegal <= w_inFire && w_illegal;

      // out_addr is the address of the held word, so a restart seen while a
      // word is still waiting is deferred until that word is handshaken.
      if (w_outFire) begin
        r_emitCnt     <= r_emitCnt + 16'd1;
        r_outAddr     <= (restart || r_restartPend) ? BASE_ADDR
                                                    : r_outAddr + ADDR_STEP;
        r_restartPend <= 1'b0;
      end else if (restart) begin
        if (r_outValid) begin
          r_restartPend <= 1'b1;
        end else begin
          r_outAddr <= BASE_ADDR;
        end
      end

      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_outInstr <= w_word;
            r_outValid <= 1'b1;
            r_state    <= ST_FULL;
`ifdef INSERT_DELAY_NOP_EN
            r_needNop  <= isDelayKind(in_kind);
`endif
          end
        end
        ST_FULL: begin
          if (w_outFire) begin
            if (w_accept) begin
              r_outInstr <= w_word;
`ifdef INSERT_DELAY_NOP_EN
              r_needNop  <= isDelayKind(in_kind);
            end else if (r_needNop) begin
              r_outInstr <= NOP_WORD;
              r_needNop  <= 1'b0;
              r_state    <= ST_NOP_PEND;
`endif
            end else begin
              r_outValid <= 1'b0;
              r_state    <= ST_EMPTY;
            end
          end
        end
`ifdef INSERT_DELAY_NOP_EN
        ST_NOP_PEND: begin
          if (w_outFire) begin
            r_outValid <= 1'b0;
            r_state    <= ST_EMPTY;
          end
        end
`endif
        default: begin
          r_outValid <= 1'b0;
          r_state    <= ST_EMPTY;
        end
      endcase
    end
  end

  assign in_ready    = w_inReady;
  assign out_valid   = r_outValid;
  assign out_instr   = r_outInstr;
  assign out_addr    = r_outAddr;
  assign err_illegal = r_errIllegal;
  assign emit_cnt    = r_emitCnt;

endmodule
